// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcode constants, the pipeline NOP and EBREAK encodings, and the
// state type shared by the pipeline-control block and its hazard detector.
package rv32i_pkg;

    localparam logic [6:0] OPC_R_TYPE = 7'b011_0011;
    localparam logic [6:0] OPC_I_ALU  = 7'b001_0011;
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    // ADDI x0,x0,0 -- what a killed or bubbled slot turns into.
    localparam logic [31:0] NOP_IW    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_IW = 32'h0010_0073;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LD_STALL = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // True when the rs1 field of this opcode names a real source register.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OPC_R_TYPE, OPC_I_ALU, OPC_LOAD,
            OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // True when the rs2 field of this opcode names a real source register.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OPC_R_TYPE, OPC_BRANCH, OPC_STORE: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_hazard_detect.sv
// rv32i_hazard_detect: flags a load-use hazard between the load sitting in
// execute and the instruction in decode. Purely combinational.
module rv32i_hazard_detect
    import rv32i_pkg::*;
(
    input  logic [31:0] i_id_iw,
    input  logic        i_ex_wb_en,
    input  logic        i_ex_is_load,
    input  logic [4:0]  i_ex_wb_reg,
    output logic        o_hazard
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_match;
    logic       w_rs2_match;
    logic       w_unused_fields;

    assign w_opcode = i_id_iw[6:0];
    assign w_rs1    = i_id_iw[19:15];
    assign w_rs2    = i_id_iw[24:20];

    // A register field only counts when the opcode really reads it, so the
    // immediate bits of LUI/AUIPC/JAL (and rs2 of I-type) never alias a source.
    assign w_rs1_match = uses_rs1(w_opcode) && (w_rs1 == i_ex_wb_reg);
    assign w_rs2_match = uses_rs2(w_opcode) && (w_rs2 == i_ex_wb_reg);

    // x0 is never a real dependency, whatever the load targets.
    assign o_hazard = i_ex_is_load && i_ex_wb_en && (i_ex_wb_reg != 5'd0)
                      && (w_rs1_match || w_rs2_match);

    // funct7 and rd play no part in the dependency check.
    assign w_unused_fields = ^{i_id_iw[31:25], i_id_iw[11:7]};

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// rv32i_pipe_ctrl: pipeline-control FSM for a 5-stage RV32I core. Decides
// fetch/decode stalls, decode flushes and execute bubbles, handles EBREAK halt
// and keeps saturating stall/flush performance counters.
module rv32i_pipe_ctrl #(
    parameter int          CNT_W  = 16,
    parameter logic [31:0] NOP_IW = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_iw,
    input  logic             ex_wb_en,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_wb_reg,
    input  logic             jump_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_stall,
    output logic             id_stall,
    output logic             id_flush,
    output logic             ex_bubble,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    import rv32i_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic             r_flush_pend;
    logic             w_flush_pend_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_hazard;
    logic w_mem_block;
    logic w_ebreak;
    logic w_stall;
    logic w_flush;
    logic w_bubble;
    logic w_halted;
    logic w_unused_nop;

    rv32i_hazard_detect u_hazard (
        .i_id_iw      (id_iw),
        .i_ex_wb_en   (ex_wb_en),
        .i_ex_is_load (ex_is_load),
        .i_ex_wb_reg  (ex_wb_reg),
        .o_hazard     (w_hazard)
    );

    assign w_mem_block = mem_req && !mem_ready;
    assign w_ebreak    = (id_iw == EBREAK_IW);

    // The NOP encoding is applied by the ID/EX datapath when it sees
    // id_flush/ex_bubble; it is carried here so the pipeline shares one value.
    assign w_unused_nop = ^NOP_IW;

    // State register plus the "flush still owed after the memory wait" flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_flush_pend <= w_flush_pend_next;
        end
    end

    // Next-state logic; RUN resolves EBREAK, then memory wait, jump, hazard.
    always_comb begin
        w_next_state      = r_state;
        w_flush_pend_next = r_flush_pend;
        case (r_state)
            ST_RUN: begin
                if (w_ebreak)         w_next_state = ST_HALT;
                else if (w_mem_block) w_next_state = ST_MEM_WAIT;
                else if (jump_en)     w_next_state = ST_FLUSH;
                else if (w_hazard)    w_next_state = ST_LD_STALL;
            end
            ST_LD_STALL: begin
                w_next_state = w_mem_block ? ST_MEM_WAIT : ST_RUN;
            end
            ST_FLUSH: begin
                if (w_mem_block) begin
                    w_next_state      = ST_MEM_WAIT;
                    w_flush_pend_next = 1'b1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_next_state      = r_flush_pend ? ST_FLUSH : ST_RUN;
                    w_flush_pend_next = 1'b0;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state      = ST_RUN;
                w_flush_pend_next = 1'b0;
            end
        endcase
    end

    // Control outputs from state and live inputs; a blocked memory access
    // freezes the front end in every non-halt state so the access is not lost.
    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        w_halted = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_RUN: begin
                    if (w_ebreak) begin
                        w_bubble = 1'b1;
                    end else if (w_mem_block || (!jump_en && w_hazard)) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                ST_LD_STALL: begin
                    w_stall  = w_mem_block;
                    w_bubble = w_mem_block;
                end
                ST_FLUSH: begin
                    w_flush  = 1'b1;
                    w_stall  = w_mem_block;
                    w_bubble = w_mem_block;
                end
                ST_MEM_WAIT: begin
                    w_flush  = r_flush_pend;
                    w_stall  = !mem_ready;
                    w_bubble = !mem_ready;
                end
                ST_HALT: begin
                    w_halted = 1'b1;
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
                default: begin
                    w_stall = 1'b0;
                end
            endcase
        end
    end

    // Saturating counters: stall cycles outside HALT, and entries into FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_state != ST_HALT) && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if ((w_next_state == ST_FLUSH) && (r_state != ST_FLUSH)
                && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign if_stall  = w_stall;
    assign id_stall  = w_stall;
    assign id_flush  = w_flush;
    assign ex_bubble = w_bubble;
    assign halted    = w_halted;
    assign state_o   = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
